// File: rtl/nibble_serial_addsub_pkg.sv
// rtl/nibble_serial_addsub_pkg.sv - shared types and constants for nibble_serial_addsub
//
// Package addsub_pkg:
//   NIBBLE_W    : width of one arithmetic slice (4 bits)
//   state_e     : FSM state encoding (IDLE, BUSY, DONE), 2 bits
//   sat_pattern : saturation limit pattern for a given width
//                 (neg=0 -> 0111..1, neg=1 -> 1000..0), LSB-aligned in SAT_MAX_W bits
package addsub_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int SAT_MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [SAT_MAX_W-1:0] sat_pattern(input logic neg, input int width);
    logic [SAT_MAX_W-1:0] p;
    p = {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    if (!neg) p = p - {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    return p;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// rtl/nibble_serial_addsub_if.sv - operand/result handshake bundle for nibble_serial_addsub
//
// Signals:
//   in_valid, in_ready, a, b, sub          : operand channel (upstream -> block)
//   out_valid, out_ready, result, cout, ovf : result channel (block -> downstream)
// Modports:
//   master : the environment side (drives operands, accepts results)
//   slave  : the arithmetic block
interface nibble_serial_addsub_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_addsub_slice.sv
// rtl/nibble_serial_addsub_slice.sv - combinational 4-bit add slice with carry
//
// Ports:
//   a, b  : input  [3:0] operand nibbles (b already inverted for subtraction)
//   cin   : input  carry in
//   s     : output [3:0] nibble sum
//   cout  : output carry out of the nibble
//   s_msb : output MSB of the nibble sum (used for signed overflow)
module addsub_nibble_slice
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                s_msb
);

  logic [NIBBLE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign s     = total[NIBBLE_W-1:0];
  assign cout  = total[NIBBLE_W];
  assign s_msb = total[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - WIDTH-bit adder/subtractor processing one nibble per clock
//
// Parameters:
//   WIDTH : operand/result width, multiple of 4 and >= 4
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : nibble_serial_addsub_if.slave (operand and result handshakes)
// Build option:
//   NIBBLE_SERIAL_ADDSUB_SATURATE_EN : clamp result to the signed limit on overflow
//
// Operands are captured on accept (B pre-inverted for subtraction, carry
// seeded with sub), then consumed LSB nibble first; each slice sum enters
// the result register from the top so after NIB cycles it is in place.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_addsub_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]          state;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [WIDTH-1:0]    result_q;
  logic                carry;
  logic                cout_q;
  logic                ovf_q;
  logic [CNT_W-1:0]    count;

  logic [NIBBLE_W-1:0] s;
  logic                s_cout;
  logic                s_msb;
  logic [WIDTH-1:0]    result_shift;
  logic [WIDTH-1:0]    result_final;
  logic                final_ovf;

  addsub_nibble_slice u_slice (
    .a     (op_a[NIBBLE_W-1:0]),
    .b     (op_b[NIBBLE_W-1:0]),
    .cin   (carry),
    .s     (s),
    .cout  (s_cout),
    .s_msb (s_msb)
  );

  generate
    if (NIB == 1) begin : g_single
      assign result_shift = s;
    end else begin : g_multi
      assign result_shift = {s, result_q[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  // Only meaningful on the last nibble, where op_a/op_b bit 3 are the operand MSBs.
  assign final_ovf = (op_a[NIBBLE_W-1] == op_b[NIBBLE_W-1]) && (s_msb != op_a[NIBBLE_W-1]);

`ifdef NIBBLE_SERIAL_ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pattern(1'b0, WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_pattern(1'b1, WIDTH));
  assign result_final = final_ovf ? (op_a[NIBBLE_W-1] ? SAT_NEG : SAT_POS) : result_shift;
`else
  assign result_final = result_shift;
`endif

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      carry    <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.sub;
            count <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          op_a  <= op_a >> NIBBLE_W;
          op_b  <= op_b >> NIBBLE_W;
          carry <= s_cout;
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            result_q <= result_final;
            cout_q   <= s_cout;
            ovf_q    <= final_ovf;
            state    <= S_DONE;
          end else begin
            result_q <= result_shift;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb/tb_nibble_serial_addsub.sv - scoreboard bench for nibble_serial_addsub (WIDTH=16 and WIDTH=4)
module tb_nibble_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [17:0] sb16[$];
  logic [17:0] sb4[$];

  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.WIDTH(16)) i16 ();
  nibble_serial_addsub_if #(.WIDTH(4))  i4 ();

  nibble_serial_addsub #(.WIDTH(16)) d16 (.clk(clk), .rst(rst), .bus(i16.slave));
  nibble_serial_addsub #(.WIDTH(4))  d4  (.clk(clk), .rst(rst), .bus(i4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: {ovf, cout, result[15:0]} from whole-word arithmetic at width w.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic [16:0] mask, bb, full, r;
    logic c, ov, am;
    mask = (17'd1 << w) - 17'd1;
    bb   = s ? (~{1'b0, b} & mask) : {1'b0, b};
    full = {1'b0, a} + bb + {16'd0, s};
    r    = full & mask;
    c    = full[w];
    am   = a[w-1];
    ov   = (am == bb[w-1]) && (r[w-1] != am);
`ifdef NIBBLE_SERIAL_ADDSUB_SATURATE_EN
    if (ov) r = am ? (17'd1 << (w - 1)) : ((17'd1 << (w - 1)) - 17'd1);
`endif
    return {ov, c, r[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready16();
    int n = 0;
    while (!i16.in_ready && n < 40) begin tick(); n++; end
    if (!i16.in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
    logic [17:0] exp;
    int lat;
    wait_ready16();
    i16.a = a; i16.b = b; i16.sub = s; i16.in_valid = 1'b1;
    sb16.push_back(model(16, a, b, s));
    tick();
    i16.in_valid = 1'b0;
    lat = 0;
    while (!i16.out_valid && lat < 50) begin tick(); lat++; end
    check("latency16", lat, 4);
    exp = (sb16.size() != 0) ? sb16.pop_front() : 18'h0;
    check("result16", {16'd0, i16.result}, {16'd0, exp[15:0]});
    check("cout16", {31'd0, i16.cout}, {31'd0, exp[16]});
    check("ovf16", {31'd0, i16.ovf}, {31'd0, exp[17]});
    for (int i = 0; i < hold; i++) begin
      i16.in_valid = 1'b1; i16.a = ~a; i16.b = ~b;
      tick();
      check("hold_result", {16'd0, i16.result}, {16'd0, exp[15:0]});
      check("hold_flags", {30'd0, i16.cout, i16.ovf}, {30'd0, exp[16], exp[17]});
      check("hold_ready_valid", {30'd0, i16.in_ready, i16.out_valid}, 32'd1);
    end
    i16.in_valid = 1'b0; i16.a = a; i16.b = b;
    i16.out_ready = 1'b1;
    tick();
    i16.out_ready = 1'b0;
    if (hold > 0) check("idle_after_ack", {30'd0, i16.in_ready, i16.out_valid}, 32'd2);
  endtask

  initial begin
    logic [17:0] exp;
    int lat, k, last_done, cyc;
    logic [3:0] va, vb;
    logic vs;

    i16.in_valid = 0; i16.a = 0; i16.b = 0; i16.sub = 0; i16.out_ready = 0;
    i4.in_valid = 0;  i4.a = 0;  i4.b = 0;  i4.sub = 0;  i4.out_ready = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready_valid16", {30'd0, i16.in_ready, i16.out_valid}, 32'd2);
    check("rst_result16", {16'd0, i16.result}, 32'd0);
    check("rst_flags16", {30'd0, i16.cout, i16.ovf}, 32'd0);
    check("rst_ready_valid4", {30'd0, i4.in_ready, i4.out_valid}, 32'd2);

    run_op16(16'h1234, 16'h0FFF, 1'b0, 0);
    run_op16(16'h0005, 16'h0007, 1'b1, 0);
    run_op16(16'h0007, 16'h0005, 1'b1, 0);
    run_op16(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op16(16'h8000, 16'h0001, 1'b1, 0);
    run_op16(16'h8000, 16'h8000, 1'b0, 0);
    run_op16(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_op16(16'hA5C3, 16'h3C5A, 1'b0, 5);
    for (int i = 0; i < 8; i++)
      run_op16(16'($urandom), 16'($urandom), 1'($urandom), i % 3);

    // Abort on the second BUSY cycle.
    wait_ready16();
    i16.a = 16'h1111; i16.b = 16'h2222; i16.sub = 1'b0; i16.in_valid = 1'b1;
    tick();
    i16.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready_valid", {30'd0, i16.in_ready, i16.out_valid}, 32'd2);
    check("midrst_result", {16'd0, i16.result}, 32'd0);
    run_op16(16'h0001, 16'h0001, 1'b0, 0);

    // WIDTH=4: single-cycle latency.
    i4.a = 4'hF; i4.b = 4'h1; i4.sub = 1'b0; i4.in_valid = 1'b1;
    sb4.push_back(model(4, 16'hF, 16'h1, 1'b0));
    tick();
    i4.in_valid = 1'b0;
    lat = 0;
    while (!i4.out_valid && lat < 20) begin tick(); lat++; end
    check("latency4", lat, 1);
    exp = (sb4.size() != 0) ? sb4.pop_front() : 18'h0;
    check("result4", {28'd0, i4.result}, {28'd0, exp[3:0]});
    check("flags4", {30'd0, i4.cout, i4.ovf}, {30'd0, exp[16], exp[17]});
    i4.out_ready = 1'b1;
    tick();

    // WIDTH=4 back-to-back with out_ready tied high: one result every 3 cycles.
    k = 0; last_done = -1; cyc = 0;
    while (cyc < 60 && (k < 8 || sb4.size() != 0)) begin
      if (i4.out_valid) begin
        exp = (sb4.size() != 0) ? sb4.pop_front() : 18'h0;
        check("b2b_result4", {28'd0, i4.result}, {28'd0, exp[3:0]});
        check("b2b_flags4", {30'd0, i4.cout, i4.ovf}, {30'd0, exp[16], exp[17]});
        if (last_done >= 0) check("b2b_period4", cyc - last_done, 3);
        last_done = cyc;
      end
      if (i4.in_ready && k < 8) begin
        va = 4'($urandom); vb = 4'($urandom); vs = 1'($urandom);
        if (k == 0) begin va = 4'h7; vb = 4'h1; vs = 1'b0; end
        if (k == 1) begin va = 4'h8; vb = 4'h1; vs = 1'b1; end
        i4.a = va; i4.b = vb; i4.sub = vs; i4.in_valid = 1'b1;
        sb4.push_back(model(4, {12'd0, va}, {12'd0, vb}, vs));
        k++;
      end else if (!i4.in_ready && k == 8) begin
        i4.in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    i4.in_valid = 1'b0;
    check("b2b_ops_done", k, 8);
    check("sb4_empty", sb4.size(), 0);
    check("sb16_empty", sb16.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit nibble per clock, least-significant nibble first. Each nibble goes through a 4-bit add/sub slice, and the carry is registered between cycles. Upstream issues operand pairs over a valid/ready handshake. Downstream collects the result, carry-out and signed-overflow flag over a second valid/ready handshake. The block trades latency for area in wide arithmetic paths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
NIB, WIDTH/4, derived local constant: number of nibble cycles per operation.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream has an operand pair.
in_ready  output  1  block can accept an operand pair.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = A+B, 1 = A-B; sampled with the operands.
out_valid  output  1  result is available.
out_ready  input  1  downstream accepts the result.
result  output  WIDTH  sum or difference.
cout  output  1  final carry-out. Add: unsigned carry. Sub: 1 = no borrow (A >= B unsigned).
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock `clk`; synchronous, active-high reset `rst`.
- Reset values:
  - FSM is in IDLE.
  - in_ready=1, out_valid=0.
  - result, cout and ovf are 0.
  - Carry register and operand shift registers are 0.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&&in_ready, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Stay for exactly NIB cycles.
  - DONE: out_valid=1, in_ready=0. When out_ready, go to IDLE.
- Accept edge:
  - Register a into opA, and b^{WIDTH{sub}} into opB.
  - Load the carry register with sub.
  - Clear the nibble counter.
- Each BUSY cycle:
  - The slice computes opA[3:0] + opB[3:0] + carry.
  - The 4-bit sum shifts into result from the MSB side (result <= {sum, result[WIDTH-1:4]}).
  - opA and opB shift right by 4. The slice carry-out is registered as carry.
  - The counter increments. When count==NIB-1, go to DONE.
- Entering DONE:
  - cout = last slice carry-out.
  - ovf = (opA_msb == opB_msb) && (sum_msb != opA_msb), using the final nibble's MSBs. opB here is the inverted B when subtracting.
- Latency: out_valid rises NIB cycles after the accept edge. With WIDTH=4 this is 1 cycle.
- Throughput: one operation per NIB+2 cycles at best. There is no overlap: no accept is possible in the DONE→IDLE cycle.
- Backpressure: while out_valid=1 and out_ready=0, result, cout and ovf hold stable.
- Input-side rules:
  - in_valid while in BUSY or DONE is ignored (in_ready=0).
  - Upstream must hold a, b and sub stable until the handshake completes.
- Reset mid-operation: rst in any state aborts the operation immediately and restores the reset values. A partial result is never presented.
- result, cout and ovf are registered outputs with no combinational path from inputs.

Optional Feature:
Macro NIBBLE_SERIAL_ADDSUB_SATURATE_EN.
- Defined: on entering DONE with ovf=1, result is clamped. Positive overflow (opA_msb=0) gives 0111..1. Negative overflow gives 1000..0. ovf still reports 1; cout is unchanged.
- Undefined: result is the wrapped modulo-2^WIDTH value. No clamp logic is synthesised.

Decomposition:
- Shared package `addsub_pkg` holds:
  - FSM state enum (IDLE, BUSY, DONE), 2 bits.
  - Constant NIBBLE_W=4.
  - Function for the saturation max/min patterns.
- One natural sub-module, `addsub_nibble_slice`: purely combinational, inputs a[3:0], b[3:0], cin; outputs s[3:0], cout, s_msb. It is instantiated once.

Test Plan:
1. WIDTH=16, add 0x1234+0x0FFF → result 0x2233, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
2. Sub 0x0005-0x0007 → result 0xFFFE, cout=0, ovf=0. Sub 0x0007-0x0005 → 0x0002, cout=1.
3. Add 0x7FFF+0x0001 → 0x8000, ovf=1 (saturate build: 0x7FFF). Sub 0x8000-0x0001 → 0x7FFF, ovf=1, cout=1 (saturate build: 0x8000).
4. Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, a second in_valid is not accepted. Raise out_ready → IDLE next cycle, then accept.
5. Assert rst on the 2nd BUSY cycle → next cycle IDLE, in_ready=1, out_valid=0, result=0. A fresh op 0x0001+0x0001 then gives 0x0002.
6. WIDTH=4: 0xF+0x1 → result 0x0, cout=1, ovf=0, latency 1 cycle. Back-to-back ops with out_ready tied to 1 complete every 3 cycles.
